// File: rtl/fifo_byte_packer_pkg.sv
// Shared constants and helpers for the FIFO byte packer slice.
package fifo_byte_packer_pkg;

   localparam int DEF_DATA_WIDTH = 8;

   // Width of a 0..N inclusive counter; matches the FIFO's fifo_cnt.
   function automatic int cnt_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/fifo_byte_packer_outreg.sv
// Output holding register with valid/ready load and accept logic.
module fifo_byte_packer_outreg #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   input  logic         ready_i,
   output logic         valid_o,
   output logic [W-1:0] data_o,
   output logic         free_o
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign free_o  = !valid_q || ready_i;

endmodule

// File: rtl/fifo_byte_packer.sv
// Drains bytes from the sync FIFO and packs PACK_NUM of them per output word.
module fifo_byte_packer
   import fifo_byte_packer_pkg::*;
#(
   parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int  PACK_NUM   = 4,
   localparam int OUT_WIDTH  = DATA_WIDTH * PACK_NUM,
   localparam int CW         = cnt_width(PACK_NUM)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  flush,
   output logic [OUT_WIDTH-1:0]  m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [CW-1:0]         asm_cnt
);

   if (PACK_NUM < 2) begin : g_bad_pack
      $error("PACK_NUM must be at least 2");
   end

   localparam logic [CW-1:0] FULL = CW'(PACK_NUM);

   logic                 rd_pending_q;
   logic [CW-1:0]        asm_cnt_q, asm_cnt_d;
   logic [OUT_WIDTH-1:0] asm_q, asm_d;
   logic [CW-1:0]        eff_cnt;
   logic                 out_free;
   logic                 xfer;

   assign xfer    = (asm_cnt_q == FULL) && out_free && !flush;
   assign eff_cnt = xfer ? '0 : asm_cnt_q;

   // Reserve a slot for the byte already in flight before asking for another.
   assign fifo_rd_en = !fifo_empty && !flush && !rst &&
      ((int'(eff_cnt) + int'(rd_pending_q)) < PACK_NUM);

   always_comb begin
      asm_d = asm_q;
      if (rd_pending_q && !flush) begin
         for (int i = 0; i < PACK_NUM; i++) begin
            if (asm_cnt_q == CW'(i)) begin
               asm_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_rd_data;
            end
         end
      end
   end

   always_comb begin
      asm_cnt_d = asm_cnt_q + CW'(rd_pending_q);
      if (flush || xfer) begin
         asm_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pending_q <= 1'b0;
         asm_cnt_q    <= '0;
         asm_q        <= '0;
      end else begin
         rd_pending_q <= fifo_rd_en;
         asm_cnt_q    <= asm_cnt_d;
         asm_q        <= asm_d;
      end
   end

   fifo_byte_packer_outreg #(
      .W(OUT_WIDTH)
   ) u_outreg (
      .clk    (clk),
      .rst    (rst),
      .load_i (xfer),
      .data_i (asm_q),
      .ready_i(m_ready),
      .valid_o(m_valid),
      .data_o (m_data),
      .free_o (out_free)
   );

   assign asm_cnt = asm_cnt_q;

endmodule
